// File: rtl/compression_module.sv
// Instruction compressor: builds a dictionary of unique 32-bit words and emits an index or a literal per input.
// Optional macro COMPRESSION_STATS_EN adds the hit_count/miss_count statistics outputs.
module compression_module #(
   parameter int DICT_DEPTH = 16,
   parameter int IDX_W      = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_is_index,
   output logic [31:0]       out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              done,
   output logic [IDX_W:0]    dict_count,
   input  logic [IDX_W-1:0]  dict_rd_idx,
   output logic [31:0]       dict_rd_data
`ifdef COMPRESSION_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);

   localparam int CNT_W = IDX_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MATCH,
      S_EMIT,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [31:0]         r_dict [DICT_DEPTH];
   logic [CNT_W-1:0]    r_dictCount;
   logic [31:0]         r_heldInstr;
   logic                r_heldLast;
   logic                r_outValid;
   logic                r_outIsIndex;
   logic [31:0]         r_outData;
   logic [ADDR_W-1:0]   r_outAddr;
   logic                r_outLast;
   logic                r_done;
`ifdef COMPRESSION_STATS_EN
   logic [15:0]         r_hitCount;
   logic [15:0]         r_missCount;
`endif

   logic                w_hit;
   logic [IDX_W-1:0]    w_hitIdx;
   logic                w_full;

   // Scan from the top down so the lowest matching valid entry ends up selected.
   always_comb begin
      w_hit    = 1'b0;
      w_hitIdx = '0;
      for (int i = DICT_DEPTH - 1; i >= 0; i--) begin
         if ((CNT_W'(i) < r_dictCount) && (r_dict[i] == r_heldInstr)) begin
            w_hit    = 1'b1;
            w_hitIdx = IDX_W'(i);
         end
      end
   end

   assign w_full = (r_dictCount == CNT_W'(DICT_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_dictCount  <= '0;
         r_heldInstr  <= '0;
         r_heldLast   <= 1'b0;
         r_outValid   <= 1'b0;
         r_outIsIndex <= 1'b0;
         r_outData    <= '0;
         r_outAddr    <= '0;
         r_outLast    <= 1'b0;
         r_done       <= 1'b0;
         for (int i = 0; i < DICT_DEPTH; i++) begin
            r_dict[i] <= '0;
         end
`ifdef COMPRESSION_STATS_EN
         r_hitCount   <= '0;
         r_missCount  <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               // A simultaneous clear empties the dictionary before the accepted word is matched.
               if (clear) begin
                  r_dictCount <= '0;
                  r_outAddr   <= '0;
`ifdef COMPRESSION_STATS_EN
                  r_hitCount  <= '0;
                  r_missCount <= '0;
`endif
               end
               if (in_valid) begin
                  r_heldInstr <= in_instr;
                  r_heldLast  <= in_last;
                  r_state     <= S_MATCH;
               end
            end
            S_MATCH: begin
               if (w_hit) begin
                  r_outIsIndex <= 1'b1;
                  r_outData    <= {{(32 - IDX_W){1'b0}}, w_hitIdx};
`ifdef COMPRESSION_STATS_EN
                  if (r_hitCount != 16'hFFFF) r_hitCount <= r_hitCount + 16'd1;
`endif
               end else begin
                  r_outIsIndex <= 1'b0;
                  r_outData    <= r_heldInstr;
                  if (!w_full) begin
                     r_dict[r_dictCount[IDX_W-1:0]] <= r_heldInstr;
                     r_dictCount                    <= r_dictCount + CNT_W'(1);
                  end
`ifdef COMPRESSION_STATS_EN
                  if (r_missCount != 16'hFFFF) r_missCount <= r_missCount + 16'd1;
`endif
               end
               r_outLast  <= r_heldLast;
               r_outValid <= 1'b1;
               r_state    <= S_EMIT;
            end
            S_EMIT: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_outAddr  <= r_outAddr + ADDR_W'(1);
                  if (r_outLast) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready     = (r_state == S_IDLE) && !rst;
   assign out_valid    = r_outValid;
   assign out_is_index = r_outIsIndex;
   assign out_data     = r_outData;
   assign out_addr     = r_outAddr;
   assign out_last     = r_outLast;
   assign done         = r_done;
   assign dict_count   = r_dictCount;
   assign dict_rd_data = ({1'b0, dict_rd_idx} < r_dictCount) ? r_dict[dict_rd_idx] : 32'd0;
`ifdef COMPRESSION_STATS_EN
   assign hit_count    = r_hitCount;
   assign miss_count   = r_missCount;
`endif

endmodule

// File: tb/tb_compression_module.sv
// Self-checking bench for compression_module: vector table, hand-written corner sequences and a
// randomized stream checked against a queue-based dictionary model.
module tb_compression_module;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_is_index;
   logic [31:0] out_data;
   logic [31:0] out_addr;
   logic        out_last;
   logic        done;
   logic [4:0]  dict_count;
   logic [3:0]  dict_rd_idx = '0;
   logic [31:0] dict_rd_data;
`ifdef COMPRESSION_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   compression_module #(.DICT_DEPTH(16), .IDX_W(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_is_index(out_is_index),
      .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .done(done),
      .dict_count(dict_count), .dict_rd_idx(dict_rd_idx), .dict_rd_data(dict_rd_data)
`ifdef COMPRESSION_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int          nChecks = 0;
   int          nFails = 0;

   logic [31:0] mDict[$];
   logic [31:0] mAddr;

   logic        timedOut, latErr, stableErr, gotIsIdx, gotLast, gotValidAfter;
   logic [31:0] gotData, gotAddr, gotAddrAfter, gotCount;
   int          donePulses;

   typedef struct {
      logic [31:0] word;
      logic        last;
      int          stall;
      logic        isIdx;
      logic [31:0] data;
      logic [31:0] addr;
      int          count;
   } vec_t;

   vec_t tbl[4];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: got no event within cycle budget, expected event", name);
   endtask

   // Behavioural dictionary: first occurrence index if present, otherwise append while space remains.
   function automatic void modelPredict(input logic [31:0] w, output logic isIdx, output logic [31:0] data);
      isIdx = 1'b0;
      data  = w;
      for (int i = 0; i < mDict.size(); i++) begin
         if (mDict[i] == w) begin
            isIdx = 1'b1;
            data  = 32'(i);
            return;
         end
      end
      if (mDict.size() < 16) mDict.push_back(w);
   endfunction

   task automatic waitIdle();
      int t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) failNow("waitIdle");
   endtask

   task automatic applyStimulus(input logic [31:0] w, input logic l, input int stall);
      int t;
      timedOut = 1'b0; latErr = 1'b0; stableErr = 1'b0; donePulses = 0;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         timedOut = 1'b1;
         return;
      end
      in_valid = 1'b1; in_instr = w; in_last = l;
      @(negedge clk);
      in_valid = 1'b0; in_instr = $urandom; in_last = 1'b0;
      if (out_valid !== 1'b0) latErr = 1'b1;
      @(negedge clk);
      if (out_valid !== 1'b1) latErr = 1'b1;
      t = 0;
      while (out_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (out_valid !== 1'b1) begin
         timedOut = 1'b1;
         return;
      end
      gotIsIdx = out_is_index; gotData = out_data; gotAddr = out_addr;
      gotLast = out_last; gotCount = 32'(dict_count);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_is_index !== gotIsIdx ||
             out_data !== gotData || out_addr !== gotAddr || out_last !== gotLast)
            stableErr = 1'b1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      gotAddrAfter = out_addr;
      gotValidAfter = out_valid;
      for (int s = 0; s < 3; s++) begin
         if (done === 1'b1) donePulses++;
         @(negedge clk);
      end
   endtask

   task automatic checkOutput(input string name, input logic isIdx, input logic [31:0] data,
                              input logic [31:0] addr, input logic last, input int count);
      if (timedOut) begin
         failNow({name, ".timeout"});
         return;
      end
      checkVal({name, ".isIndex"}, 32'(gotIsIdx), 32'(isIdx));
      checkVal({name, ".data"}, gotData, data);
      checkVal({name, ".addr"}, gotAddr, addr);
      checkVal({name, ".last"}, 32'(gotLast), 32'(last));
      checkVal({name, ".count"}, gotCount, 32'(count));
      checkVal({name, ".latency"}, 32'(latErr), 32'd0);
      checkVal({name, ".stable"}, 32'(stableErr), 32'd0);
      checkVal({name, ".validAfter"}, 32'(gotValidAfter), 32'd0);
      checkVal({name, ".addrAfter"}, gotAddrAfter, addr + 32'd1);
      checkVal({name, ".donePulses"}, 32'(donePulses), last ? 32'd1 : 32'd0);
   endtask

   task automatic sendModel(input string name, input logic [31:0] w, input logic l, input int stall);
      logic        eIdx;
      logic [31:0] eData;
      modelPredict(w, eIdx, eData);
      applyStimulus(w, l, stall);
      checkOutput(name, eIdx, eData, mAddr, l, mDict.size());
      mAddr++;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkVal("resetInReady", 32'(in_ready), 32'd0);
      rst = 1'b0;
      mDict.delete();
      mAddr = '0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] pool[20];
      logic [31:0] x;
      logic        eIdx;
      logic [31:0] eData;

      tbl[0] = '{32'h00A0_0013, 1'b0, 0, 1'b0, 32'h00A0_0013, 32'd0, 1};
      tbl[1] = '{32'h00B0_0093, 1'b0, 1, 1'b0, 32'h00B0_0093, 32'd1, 2};
      tbl[2] = '{32'h00A0_0013, 1'b0, 5, 1'b1, 32'd0,        32'd2, 2};
      tbl[3] = '{32'h00C0_0113, 1'b1, 0, 1'b0, 32'h00C0_0113, 32'd3, 3};

      doReset();
      checkVal("rst.outValid", 32'(out_valid), 32'd0);
      checkVal("rst.outIsIndex", 32'(out_is_index), 32'd0);
      checkVal("rst.outData", out_data, 32'd0);
      checkVal("rst.outAddr", out_addr, 32'd0);
      checkVal("rst.outLast", 32'(out_last), 32'd0);
      checkVal("rst.done", 32'(done), 32'd0);
      checkVal("rst.dictCount", 32'(dict_count), 32'd0);
      checkVal("rst.inReadyIdle", 32'(in_ready), 32'd1);
      checkVal("rst.dictRead", dict_rd_data, 32'd0);

      for (int i = 0; i < 4; i++) begin
         modelPredict(tbl[i].word, eIdx, eData);
         applyStimulus(tbl[i].word, tbl[i].last, tbl[i].stall);
         checkOutput($sformatf("vec%0d", i), tbl[i].isIdx, tbl[i].data, tbl[i].addr, tbl[i].last, tbl[i].count);
         mAddr++;
      end
      for (int i = 0; i < 5; i++) begin
         dict_rd_idx = 4'(i);
         #1;
         checkVal($sformatf("tblRead%0d", i), dict_rd_data, (i < 3) ? mDict[i] : 32'd0);
      end
`ifdef COMPRESSION_STATS_EN
      checkVal("stats.hit", 32'(hit_count), 32'd1);
      checkVal("stats.miss", 32'(miss_count), 32'd3);
`endif

      // Random stream over a small pool so hits, misses and a full dictionary all occur.
      doReset();
      for (int i = 0; i < 20; i++) pool[i] = $urandom;
      for (int i = 0; i < 40; i++)
         sendModel($sformatf("rnd%0d", i), pool[$urandom_range(0, 19)], (i == 39), $urandom_range(0, 2));
      for (int i = 0; i < 16; i++) begin
         dict_rd_idx = 4'(i);
         #1;
         checkVal($sformatf("rndRead%0d", i), dict_rd_data, (i < mDict.size()) ? mDict[i] : 32'd0);
      end

      // Fill all 16 entries, then an unseen word stays literal and a repeat of entry 5 hits.
      doReset();
      for (int i = 0; i < 16; i++)
         sendModel($sformatf("fill%0d", i), 32'hF000_0000 + 32'(i * 37), 1'b0, 0);
      x = 32'hDEAD_BEEF;
      applyStimulus(x, 1'b0, 0);
      checkOutput("fillX", 1'b0, x, 32'd16, 1'b0, 16);
      applyStimulus(32'hF000_0000 + 32'(5 * 37), 1'b1, 0);
      checkOutput("fillRepeat5", 1'b1, 32'd5, 32'd17, 1'b1, 16);

      // Reset while a word is waiting in the emit state.
      waitIdle();
      in_valid = 1'b1; in_instr = 32'h1234_5678; in_last = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkVal("rstEmit.validBefore", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkVal("rstEmit.valid", 32'(out_valid), 32'd0);
      checkVal("rstEmit.count", 32'(dict_count), 32'd0);
      checkVal("rstEmit.addr", out_addr, 32'd0);
      checkVal("rstEmit.inReady", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkVal("rstEmit.idle", 32'(in_ready), 32'd1);
      mDict.delete();
      mAddr = '0;

      // Clear together with a new word: the word is matched against an empty dictionary.
      for (int i = 0; i < 3; i++)
         sendModel($sformatf("pre%0d", i), 32'h0000_1000 + 32'(i), 1'b0, 0);
      waitIdle();
      x = mDict[1];
      clear = 1'b1; in_valid = 1'b1; in_instr = x; in_last = 1'b1;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      checkVal("clr.count", 32'(dict_count), 32'd0);
      checkVal("clr.addr", out_addr, 32'd0);
      @(negedge clk);
      checkVal("clr.valid", 32'(out_valid), 32'd1);
      checkVal("clr.isIndex", 32'(out_is_index), 32'd0);
      checkVal("clr.data", out_data, x);
      checkVal("clr.outAddr", out_addr, 32'd0);
      checkVal("clr.countAfter", 32'(dict_count), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkVal("clr.done", 32'(done), 32'd1);
      checkVal("clr.addrAfter", out_addr, 32'd1);
`ifdef COMPRESSION_STATS_EN
      checkVal("clr.statsMiss", 32'(miss_count), 32'd1);
      checkVal("clr.statsHit", 32'(hit_count), 32'd0);
`endif
      @(negedge clk);
      checkVal("clr.donePulse", 32'(done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
